// File: rtl/instruction_register_mb_if.sv
// Control, W-bus input and status signals of the multi-byte instruction register.
// The tri-state operand bus is a plain port on the register itself.
interface instruction_register_mb_if #(
    parameter int BUS_W = 8
);
    logic             Li_bar;
    logic             Ei_bar;
    logic             flush;
    logic [BUS_W-1:0] data_in;
    logic [BUS_W-1:0] opcode_out;
    logic             instr_valid;
    logic [1:0]       bytes_pending;
    logic             illegal;

    modport master (
        output Li_bar, Ei_bar, flush, data_in,
        input  opcode_out, instr_valid, bytes_pending, illegal
    );

    modport slave (
        input  Li_bar, Ei_bar, flush, data_in,
        output opcode_out, instr_valid, bytes_pending, illegal
    );
endinterface

// File: rtl/instruction_register_mb.sv
// SAP-2/3 instruction register: latches an opcode byte, then 0..MAX_OPERANDS
// little-endian operand bytes from the W bus, one byte per load strobe.
module instruction_register_mb #(
    parameter int BUS_W        = 8,
    parameter int MAX_OPERANDS = 2
) (
    input  logic                          CLK,
    input  logic                          CLR,
    instruction_register_mb_if.slave      irb,
    output logic [BUS_W*MAX_OPERANDS-1:0] operand_out
);
    localparam int         OPW     = BUS_W * MAX_OPERANDS;
    localparam logic [1:0] MAX_LEN = 2'(MAX_OPERANDS);

    typedef enum logic [1:0] {
        FETCH_OPC = 2'd0,
        FETCH_ARG = 2'd1,
        READY     = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [BUS_W-1:0] opcode, opcode_nxt;
    logic [OPW-1:0]   operand, operand_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [1:0]       pending, pending_nxt;
    logic             illegal_q, illegal_nxt;
    logic [1:0]       len;

    assign len = irb.data_in[BUS_W-1 -: 2];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= FETCH_OPC;
            opcode    <= '0;
            operand   <= '0;
            idx       <= '0;
            pending   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            opcode    <= opcode_nxt;
            operand   <= operand_nxt;
            idx       <= idx_nxt;
            pending   <= pending_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        opcode_nxt  = opcode;
        operand_nxt = operand;
        idx_nxt     = idx;
        pending_nxt = pending;
        illegal_nxt = illegal_q;

        if (irb.flush) begin
            // Abort wins over a simultaneous load; the strobed byte is dropped.
            state_nxt   = FETCH_OPC;
            opcode_nxt  = '0;
            operand_nxt = '0;
            idx_nxt     = '0;
            pending_nxt = '0;
            illegal_nxt = 1'b0;
        end else if (!irb.Li_bar) begin
            unique case (state)
                FETCH_OPC, READY: begin
                    opcode_nxt  = irb.data_in;
                    operand_nxt = '0;
                    idx_nxt     = '0;
                    illegal_nxt = 1'b0;
                    if (len == 2'd0) begin
                        state_nxt   = READY;
                        pending_nxt = '0;
                    end else if (len > MAX_LEN) begin
                        state_nxt   = READY;
                        pending_nxt = '0;
                        illegal_nxt = 1'b1;
                    end else begin
                        state_nxt   = FETCH_ARG;
                        pending_nxt = len;
                    end
                end
                FETCH_ARG: begin
                    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
                        if (idx == 2'(i))
                            operand_nxt[i*BUS_W +: BUS_W] = irb.data_in;
                    end
                    idx_nxt     = idx + 2'd1;
                    pending_nxt = pending - 2'd1;
                    if (pending == 2'd1)
                        state_nxt = READY;
                end
                default: state_nxt = FETCH_OPC;
            endcase
        end
    end

    // instr_valid is exactly "in READY"; flush and CLR both leave READY.
    assign irb.opcode_out    = opcode;
    assign irb.instr_valid   = (state == READY);
    assign irb.bytes_pending = pending;
    assign irb.illegal       = illegal_q;

    assign operand_out = irb.Ei_bar ? 'z : operand;
endmodule
